// File: rtl/ldpc_sat_pkg.sv
// Shared types, default widths and saturation helpers for the
// multi-lane saturating accumulator.
package ldpc_sat_pkg;

  localparam int LANES_DEF = 4;
  localparam int IN_W_DEF  = 9;
  localparam int ACC_W_DEF = 12;
  localparam int OUT_W_DEF = 8;
  localparam int DEG_W_DEF = 4;

  // EMPTY: accumulators zero, no beat taken yet; BUSY: mid-frame
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } acc_state_e;

  // Largest positive value of a w-bit signed message
  function automatic int sat_max_pos(int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Most negative allowed value; symmetric mode gives up the lone -2^(w-1)
  function automatic int sat_max_neg(int w, logic sym);
    return sym ? -((1 << (w - 1)) - 1) : -(1 << (w - 1));
  endfunction

  // LSB position of lane k inside a packed bus of w-bit lanes
  function automatic int lane_lsb(int lane, int w);
    return lane * w;
  endfunction

  // Index of the last beat a frame may have before it is forced closed
  function automatic int max_beat(int deg_w);
    return (1 << deg_w) - 1;
  endfunction

endpackage

// File: rtl/sat_accum_pipe_sat_lane.sv
// One combinational lane: widened add with accumulator clamp, then
// reduction to the output width with optional symmetric saturation.
module sat_lane
  import ldpc_sat_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic signed [IN_W-1:0]  din_i,
  input  logic                    cfg_sym,
  output logic signed [ACC_W-1:0] sum_o,
  output logic signed [OUT_W-1:0] out_o,
  output logic                    sat_o
);

  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX  = OUT_W'(sat_max_pos(OUT_W));
  localparam logic signed [OUT_W-1:0] OUT_MIN  = OUT_W'(sat_max_neg(OUT_W, 1'b0));
  localparam logic signed [OUT_W-1:0] OUT_MINS = OUT_W'(sat_max_neg(OUT_W, 1'b1));

  logic signed [ACC_W:0]      wide;
  logic        [ACC_W-OUT_W:0] top_bits;
  logic                       fits;

  // Add one guard bit wide, then clamp back into the accumulator range
  always_comb begin
    wide = {acc_i[ACC_W-1], acc_i} + {{(ACC_W+1-IN_W){din_i[IN_W-1]}}, din_i};
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sum_o = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_o = wide[ACC_W-1:0];
    end
  end

  // Reduce to OUT_W; flag any lane whose value changed in the reduction
  always_comb begin
    top_bits = sum_o[ACC_W-1:OUT_W-1];
    fits     = (&top_bits) | ~(|top_bits);
    if (!fits) begin
      out_o = sum_o[ACC_W-1] ? (cfg_sym ? OUT_MINS : OUT_MIN) : OUT_MAX;
    end else if (cfg_sym && (sum_o[OUT_W-1:0] == OUT_MIN)) begin
      out_o = OUT_MINS;
    end else begin
      out_o = sum_o[OUT_W-1:0];
    end
    sat_o = (sum_o != {{(ACC_W-OUT_W){out_o[OUT_W-1]}}, out_o});
  end

endmodule

// File: rtl/sat_accum_pipe.sv
// Multi-lane saturating frame accumulator with a registered
// valid/ready result stage, per-lane saturation flags and a
// running saturation counter.
module sat_accum_pipe
  import ldpc_sat_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEG_W = DEG_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_sym,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  output logic [15:0]            sat_cnt,
  output logic                   frame_err
);

  localparam logic [DEG_W-1:0] LAST_CNT = DEG_W'(max_beat(DEG_W));

  acc_state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q [LANES];
  logic signed [ACC_W-1:0] acc_d [LANES];
  logic signed [ACC_W-1:0] lane_sum [LANES];
  logic signed [OUT_W-1:0] lane_out [LANES];
  logic [LANES-1:0]        lane_sat;

  logic [DEG_W-1:0]       cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [LANES*OUT_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]       out_sat_q, out_sat_d;
  logic [15:0]            sat_cnt_q, sat_cnt_d;
  logic                   frame_err_q, frame_err_d;
  logic [15:0]            sat_add;
  logic                   beat_fire, force_close, last_fire;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sat_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .acc_i   (acc_q[k]),
      .din_i   (in_data[lane_lsb(k, IN_W) +: IN_W]),
      .cfg_sym (cfg_sym),
      .sum_o   (lane_sum[k]),
      .out_o   (lane_out[k]),
      .sat_o   (lane_sat[k])
    );
  end

  // Handshake decode: the only combinational output path is out_ready -> in_ready
  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    beat_fire   = in_valid && in_ready;
    force_close = (cnt_q == LAST_CNT);
    last_fire   = beat_fire && (in_last || force_close);
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Frame state transitions
  always_comb begin
    state_d = state_q;
    if (last_fire)      state_d = ST_EMPTY;
    else if (beat_fire) state_d = ST_BUSY;
  end

  // Number of lanes clamped in the result about to be loaded
  always_comb begin
    sat_add = '0;
    // NOTE: blocking accumulation is correct here; this is combinational, not state.
    for (int k = 0; k < LANES; k++) sat_add = sat_add + 16'(lane_sat[k]);
  end

  // Next values for accumulators, beat count and the output stage
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch behind.
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sat_cnt_d   = sat_cnt_q;
    frame_err_d = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (last_fire) begin
      for (int k = 0; k < LANES; k++) begin
        acc_d[k] = '0;
        out_data_d[lane_lsb(k, OUT_W) +: OUT_W] = lane_out[k];
      end
      cnt_d       = '0;
      out_valid_d = 1'b1;
      out_sat_d   = lane_sat;
      sat_cnt_d   = sat_cnt_q + sat_add;
      frame_err_d = !in_last;
    end else if (beat_fire) begin
      acc_d = lane_sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: the accumulator array is reset on purpose; an aborted frame must leave no residue.
    if (rst) begin
      for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      sat_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_cnt_q   <= sat_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_cnt   = sat_cnt_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sat_accum_pipe.sv
// Directed bench for sat_accum_pipe with default widths
// (4 lanes, 9-bit in, 12-bit accumulator, 8-bit out, 16-beat frames).
module tb_sat_accum_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_sym;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_sat;
  logic [15:0] sat_cnt;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  sat_accum_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_sym   (cfg_sym),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_cnt   (sat_cnt),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] pk(int a, int b, int c, int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  function automatic logic [31:0] po(int a, int b, int c, int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one accepted-or-not beat for a single clock, then sample #1 after the edge
  task automatic beat(input logic [35:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    cfg_sym   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle();
    idle();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_out_sat",   32'(out_sat), 32'd0);
    check("rst_sat_cnt",   32'(sat_cnt), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready), 32'd1);

    // Three-beat frame on lane 0: 100 + 20 - 30 = 90
    beat(pk(100, 0, 0, 0), 1'b0);
    beat(pk(20, 0, 0, 0), 1'b0);
    check("a_no_early_valid", 32'(out_valid), 32'd0);
    beat(pk(-30, 0, 0, 0), 1'b1);
    check("a_valid", 32'(out_valid), 32'd1);
    check("a_data",  out_data, po(90, 0, 0, 0));
    check("a_sat",   32'(out_sat), 32'd0);
    check("a_cnt",   32'(sat_cnt), 32'd0);
    idle();
    check("a_valid_drop", 32'(out_valid), 32'd0);

    // Lane 0 overflows positive, lane 1 negative (asymmetric)
    beat(pk(200, -200, 0, 0), 1'b0);
    beat(pk(100, -100, 0, 0), 1'b1);
    check("b_data", out_data, po(127, -128, 0, 0));
    check("b_sat",  32'(out_sat), 32'b0011);
    check("b_cnt",  32'(sat_cnt), 32'd2);

    // Symmetric mode sampled on the last beat only: lane1 -300, lane2 -128, lane3 -127
    cfg_sym = 1'b0;
    beat(pk(0, -200, -100, -100), 1'b0);
    cfg_sym = 1'b1;
    beat(pk(0, -100, -28, -27), 1'b1);
    cfg_sym = 1'b0;
    check("c_data", out_data, po(0, -127, -127, -127));
    check("c_sat",  32'(out_sat), 32'b0110);
    check("c_cnt",  32'(sat_cnt), 32'd4);
    idle();

    // Forced close: 16 beats of +255, in_last never set
    for (int i = 0; i < 15; i++) beat(pk(255, 255, 255, 255), 1'b0);
    check("f_no_valid_15", 32'(out_valid), 32'd0);
    check("f_no_err_15",   32'(frame_err), 32'd0);
    beat(pk(255, 255, 255, 255), 1'b0);
    check("f_valid",     32'(out_valid), 32'd1);
    check("f_data",      out_data, 32'h7F7F7F7F);
    check("f_sat",       32'(out_sat), 32'hF);
    check("f_frame_err", 32'(frame_err), 32'd1);
    check("f_cnt",       32'(sat_cnt), 32'd8);
    idle();
    check("f_err_pulse", 32'(frame_err), 32'd0);

    // Backpressure: result held, next last beat stalled, then loaded without a bubble
    out_ready = 1'b0;
    beat(pk(10, 20, 30, 40), 1'b1);
    check("p_valid", 32'(out_valid), 32'd1);
    in_data  = pk(1, 2, 3, 4);
    in_last  = 1'b1;
    in_valid = 1'b1;
    #1;
    check("p_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("p_hold_valid", 32'(out_valid), 32'd1);
    check("p_hold_data",  out_data, po(10, 20, 30, 40));
    out_ready = 1'b1;
    #1;
    check("p_in_ready_high", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("p_reload_valid", 32'(out_valid), 32'd1);
    check("p_reload_data",  out_data, po(1, 2, 3, 4));
    idle();
    check("p_drain", 32'(out_valid), 32'd0);

    // Back-to-back single-beat frames, one result per cycle
    beat(pk(50, 0, 0, 0), 1'b1);
    check("s1_data", out_data, po(50, 0, 0, 0));
    beat(pk(-200, 0, 0, 0), 1'b1);
    check("s2_valid", 32'(out_valid), 32'd1);
    check("s2_data",  out_data, po(-128, 0, 0, 0));
    check("s2_cnt",   32'(sat_cnt), 32'd9);
    beat(pk(127, -128, 0, 1), 1'b1);
    check("s3_valid", 32'(out_valid), 32'd1);
    check("s3_data",  out_data, po(127, -128, 0, 1));
    check("s3_sat",   32'(out_sat), 32'd0);
    idle();

    // Reset mid-frame discards the partial sum
    beat(pk(35, 0, 0, 0), 1'b0);
    beat(pk(35, 0, 0, 0), 1'b0);
    rst = 1'b1;
    idle();
    check("r_valid", 32'(out_valid), 32'd0);
    check("r_data",  out_data, 32'd0);
    check("r_cnt",   32'(sat_cnt), 32'd0);
    rst = 1'b0;
    beat(pk(5, 0, 0, 0), 1'b0);
    beat(pk(5, 0, 0, 0), 1'b1);
    check("r_post_valid", 32'(out_valid), 32'd1);
    check("r_post_data",  out_data, po(10, 0, 0, 0));
    check("r_post_sat",   32'(out_sat), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
